dc_req_upload: RTL and testbench

Data-cache request upload serializer. It accepts a 48-bit, 3-flit cache request (shreq/exreq) from the data-cache side in one cycle. It then streams the request as three 16-bit flits into the downstream request FIFO, under that FIFO's ready handshake. It sits between the data-cache request generator and the req FIFO feeding the ring network interface.

---
 rtl/dc_req_upload.sv | 75 +++++++
 tb/tb_dc_req_upload.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/dc_req_upload.sv
// Data-cache request upload serializer: captures one 48-bit request while idle
// and streams it as three 16-bit flits, head first, under the req FIFO ready handshake.
module dc_req_upload (
  input  logic        clk,
  input  logic        rst,
  input  logic [47:0] dc_flits_req,
  input  logic        v_dc_flits_req,
  input  logic        req_fifo_rdy,
  output logic [15:0] dc_flit_out,
  output logic        v_dc_flit_out,
  output logic        dc_req_upload_state
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t      state_reg;
  logic [1:0]  cnt_reg;
  logic [47:0] req_reg;
  logic [15:0] flit [4];

  // Flit view of the held request; slot 3 is unreachable and reads as zero.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_flit
      assign flit[gi] = req_reg[47-16*gi -: 16];
    end
  endgenerate
  assign flit[3] = 16'h0000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 2'd0;
      req_reg   <= 48'h0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (v_dc_flits_req) begin
            req_reg   <= dc_flits_req;
            cnt_reg   <= 2'd0;
            state_reg <= BUSY;
          end
        end
        BUSY: begin
          if (req_fifo_rdy) begin
            // Last flit leaving takes priority; any new request waits for IDLE.
            if (cnt_reg == 2'd2) begin
              cnt_reg   <= 2'd0;
              req_reg   <= 48'h0;
              state_reg <= IDLE;
            end else begin
              cnt_reg <= cnt_reg + 2'd1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_comb begin
    v_dc_flit_out = 1'b0;
    dc_flit_out   = 16'h0000;
    if (state_reg == BUSY) begin
      v_dc_flit_out = 1'b1;
      dc_flit_out   = flit[cnt_reg];
    end
  end

  assign dc_req_upload_state = state_reg;

endmodule

// File: tb/tb_dc_req_upload.sv
// Bench for dc_req_upload: directed vector table, hand-built reset sequences,
// and randomized traffic checked against a flit-queue reference model.
module tb_dc_req_upload;

  logic        clk;
  logic        rst;
  logic [47:0] dc_flits_req;
  logic        v_dc_flits_req;
  logic        req_fifo_rdy;
  logic [15:0] dc_flit_out;
  logic        v_dc_flit_out;
  logic        dc_req_upload_state;

  int checks;
  int errors;

  dc_req_upload dut (
    .clk                 (clk),
    .rst                 (rst),
    .dc_flits_req        (dc_flits_req),
    .v_dc_flits_req      (v_dc_flits_req),
    .req_fifo_rdy        (req_fifo_rdy),
    .dc_flit_out         (dc_flit_out),
    .v_dc_flit_out       (v_dc_flit_out),
    .dc_req_upload_state (dc_req_upload_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [47:0] data;
    logic        rdy;
    logic        exp_v;
    logic [15:0] exp_flit;
    logic        exp_state;
  } vec_t;

  vec_t vecs [23];

  task automatic check(input string name, input logic ev, input logic [15:0] ef, input logic es);
    checks++;
    if (v_dc_flit_out !== ev || dc_flit_out !== ef || dc_req_upload_state !== es) begin
      errors++;
      $display("FAIL %s: got v=%b flit=%h state=%b, expected v=%b flit=%h state=%b",
               name, v_dc_flit_out, dc_flit_out, dc_req_upload_state, ev, ef, es);
    end else begin
      $display("ok   %s: v=%b flit=%h state=%b", name, v_dc_flit_out, dc_flit_out, dc_req_upload_state);
    end
  endtask

  task automatic set_vec(input int i, input logic v, input logic [47:0] d, input logic r,
                         input logic ev, input logic [15:0] ef, input logic es);
    vecs[i].v = v; vecs[i].data = d; vecs[i].rdy = r;
    vecs[i].exp_v = ev; vecs[i].exp_flit = ef; vecs[i].exp_state = es;
  endtask

  // Reference model: the flits still owed downstream, oldest first.
  logic [15:0] q [$];

  task automatic model_edge(input logic r, input logic v, input logic [47:0] d, input logic rdy);
    if (r) begin
      q.delete();
    end else if (q.size() == 0) begin
      if (v) begin
        q.push_back(d[47:32]);
        q.push_back(d[31:16]);
        q.push_back(d[15:0]);
      end
    end else if (rdy) begin
      void'(q.pop_front());
    end
  endtask

  initial begin
    logic [15:0] ef;
    logic        ev;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    dc_flits_req = 48'h0;
    v_dc_flits_req = 1'b0;
    req_fifo_rdy = 1'b0;

    // Reset state
    @(posedge clk); #1;
    check("reset_held", 1'b0, 16'h0000, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("reset_release", 1'b0, 16'h0000, 1'b0);

    // Capture with stall, then drain
    set_vec(0,  1, 48'h123456789abc, 0, 1, 16'h1234, 1);
    set_vec(1,  0, 48'h0,            0, 1, 16'h1234, 1);
    set_vec(2,  0, 48'h0,            0, 1, 16'h1234, 1);
    set_vec(3,  0, 48'h0,            1, 1, 16'h5678, 1);
    set_vec(4,  0, 48'h0,            1, 1, 16'h9abc, 1);
    set_vec(5,  0, 48'h0,            1, 0, 16'h0000, 0);
    // Ignore while busy, including on the last-transfer edge
    set_vec(6,  1, 48'h123456789abc, 1, 1, 16'h1234, 1);
    set_vec(7,  1, 48'h2016c0de0330, 1, 1, 16'h5678, 1);
    set_vec(8,  1, 48'h2016c0de0330, 1, 1, 16'h9abc, 1);
    set_vec(9,  1, 48'h2016c0de0330, 1, 0, 16'h0000, 0);
    set_vec(10, 1, 48'h2016c0de0330, 0, 1, 16'h2016, 1);
    // Intermittent ready 1,0,1,1
    set_vec(11, 0, 48'h0,            1, 1, 16'hc0de, 1);
    set_vec(12, 0, 48'h0,            0, 1, 16'hc0de, 1);
    set_vec(13, 0, 48'h0,            1, 1, 16'h0330, 1);
    set_vec(14, 0, 48'h0,            1, 0, 16'h0000, 0);
    // Back-to-back with v and rdy held high
    set_vec(15, 1, 48'haaaabbbbcccc, 1, 1, 16'haaaa, 1);
    set_vec(16, 1, 48'haaaabbbbcccc, 1, 1, 16'hbbbb, 1);
    set_vec(17, 1, 48'haaaabbbbcccc, 1, 1, 16'hcccc, 1);
    set_vec(18, 1, 48'haaaabbbbcccc, 1, 0, 16'h0000, 0);
    set_vec(19, 1, 48'haaaabbbbcccc, 1, 1, 16'haaaa, 1);
    set_vec(20, 0, 48'h0,            1, 1, 16'hbbbb, 1);
    set_vec(21, 0, 48'h0,            1, 1, 16'hcccc, 1);
    set_vec(22, 0, 48'h0,            1, 0, 16'h0000, 0);

    for (int i = 0; i < 23; i++) begin
      v_dc_flits_req = vecs[i].v;
      dc_flits_req   = vecs[i].data;
      req_fifo_rdy   = vecs[i].rdy;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), vecs[i].exp_v, vecs[i].exp_flit, vecs[i].exp_state);
    end

    // Reset mid-transfer: clears asynchronously, old flits never reappear
    v_dc_flits_req = 1'b1; dc_flits_req = 48'hdeadbeefcafe; req_fifo_rdy = 1'b1;
    @(posedge clk); #1;
    check("mid_head", 1'b1, 16'hdead, 1'b1);
    v_dc_flits_req = 1'b0; dc_flits_req = 48'h0;
    @(posedge clk); #1;
    check("mid_second", 1'b1, 16'hbeef, 1'b1);
    #2 rst = 1'b1;
    #1 check("mid_async_clear", 1'b0, 16'h0000, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_after_release", 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check($sformatf("mid_idle%0d", i), 1'b0, 16'h0000, 1'b0);
    end

    // Randomized traffic against the queue model
    q.delete();
    for (int i = 0; i < 1500; i++) begin
      rst            = ($urandom_range(0, 99) == 0);
      v_dc_flits_req = ($urandom_range(0, 2) != 0);
      dc_flits_req   = {$urandom(), $urandom()} ;
      req_fifo_rdy   = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      model_edge(rst, v_dc_flits_req, dc_flits_req, req_fifo_rdy);
      #1;
      ev = (q.size() != 0);
      ef = ev ? q[0] : 16'h0000;
      check($sformatf("rand%0d", i), ev, ef, ev);
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
